// File: rtl/hu_audiodec_rtl_dma_chunked_pkg.sv
// Shared types, mode constants, debug layout and per-lane helpers for the chunked audio-decoder socket.
package hu_audiodec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam logic [1:0] MODE_COPY = 2'd0;
  localparam logic [1:0] MODE_NEG  = 2'd1;
  localparam logic [1:0] MODE_ASR  = 2'd2;

  localparam int DBG_STATE_LSB = 0;
  localparam int DBG_ERR_BIT   = 3;
  localparam int DBG_CHUNK_LSB = 16;

  function automatic logic [2:0] size_code(input int width);
    return (width == 64) ? 3'b011 : 3'b010;
  endfunction

  // Mode 3 (reserved) falls through to copy; the error flag is tracked elsewhere.
  function automatic logic [31:0] lane_op(input logic [1:0] mode, input logic [4:0] shamt,
                                          input logic [31:0] x);
    logic [31:0] r;
    case (mode)
      MODE_NEG: r = -x;
      MODE_ASR: r = $unsigned($signed(x) >>> shamt);
      default:  r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hu_audiodec_rtl_dma_chunked_if.sv
// ESP-style DMA read/write control and channel bundle; master is the accelerator side.
interface hu_audiodec_rtl_dma_chunked_if #(
  parameter int DMA_WIDTH = 32
);
  logic                 dma_read_ctrl_valid;
  logic                 dma_read_ctrl_ready;
  logic [31:0]          dma_read_ctrl_data_index;
  logic [31:0]          dma_read_ctrl_data_length;
  logic [2:0]           dma_read_ctrl_data_size;
  logic                 dma_read_chnl_valid;
  logic                 dma_read_chnl_ready;
  logic [DMA_WIDTH-1:0] dma_read_chnl_data;
  logic                 dma_write_ctrl_valid;
  logic                 dma_write_ctrl_ready;
  logic [31:0]          dma_write_ctrl_data_index;
  logic [31:0]          dma_write_ctrl_data_length;
  logic [2:0]           dma_write_ctrl_data_size;
  logic                 dma_write_chnl_valid;
  logic                 dma_write_chnl_ready;
  logic [DMA_WIDTH-1:0] dma_write_chnl_data;

  modport master (
    output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
           dma_read_ctrl_data_size, dma_read_chnl_ready,
           dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
           dma_write_ctrl_data_size, dma_write_chnl_valid, dma_write_chnl_data,
    input  dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
           dma_write_ctrl_ready, dma_write_chnl_ready
  );

  modport slave (
    input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
           dma_read_ctrl_data_size, dma_read_chnl_ready,
           dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
           dma_write_ctrl_data_size, dma_write_chnl_valid, dma_write_chnl_data,
    output dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
           dma_write_ctrl_ready, dma_write_chnl_ready
  );
endinterface

// File: rtl/hu_audiodec_rtl_dma_chunked_chunk_buf.sv
// Chunk staging buffer: BUF_DEPTH x DMA_WIDTH, synchronous write, combinational read.
module hu_audiodec_chunk_buf #(
  parameter  int DMA_WIDTH = 32,
  parameter  int BUF_DEPTH = 64,
  localparam int AW        = $clog2(BUF_DEPTH)
) (
  input  logic                 clk,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [DMA_WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]        rd_addr_i,
  output logic [DMA_WIDTH-1:0] rd_data_o
);
  logic [DMA_WIDTH-1:0] mem_q [BUF_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/hu_audiodec_rtl_dma_chunked.sv
// Chunked load/compute/store accelerator: reads len beats in BUF_DEPTH chunks, applies a
// per-lane op, writes each chunk back at wr_offset + base, then pulses acc_done.
module hu_audiodec_rtl_dma_chunked
  import hu_audiodec_pkg::*;
#(
  parameter int DMA_WIDTH = 32,
  parameter int BUF_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] conf_info_len,
  input  logic [31:0] conf_info_wr_offset,
  input  logic [31:0] conf_info_mode,
  input  logic [31:0] conf_info_shift,
  input  logic        conf_done,
  output logic        acc_done,
  output logic [31:0] debug,
  hu_audiodec_rtl_dma_chunked_if.master dma
);
  localparam int         LANES     = DMA_WIDTH / 32;
  localparam int         AW        = $clog2(BUF_DEPTH);
  localparam int         CW        = AW + 1;
  localparam logic [2:0] SIZE_CODE = size_code(DMA_WIDTH);

  state_e        state_q, state_d;
  logic [31:0]   wr_off_q, wr_off_d;
  logic [1:0]    mode_q, mode_d;
  logic [4:0]    shift_q, shift_d;
  logic [31:0]   rem_q, rem_d;
  logic [31:0]   base_q, base_d;
  logic [CW-1:0] clen_q, clen_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          err_q, err_d;
  logic [15:0]   chunks_q, chunks_d;

  logic                 rd_ctrl_hs, rd_beat, rd_last;
  logic                 wr_ctrl_hs, wr_beat, wr_last;
  logic [DMA_WIDTH-1:0] buf_rd_dat, wr_dat;
  logic                 unused_cfg;

  assign unused_cfg = ^{conf_info_mode[31:2], conf_info_shift[31:5]};

  function automatic logic [CW-1:0] chunk_len(input logic [31:0] rem);
    return (rem >= 32'(BUF_DEPTH)) ? CW'(BUF_DEPTH) : rem[CW-1:0];
  endfunction

  assign rd_ctrl_hs = (state_q == ST_RD_REQ) && dma.dma_read_ctrl_ready;
  assign rd_beat    = (state_q == ST_RD_DATA) && (rcnt_q < clen_q) && dma.dma_read_chnl_valid;
  assign rd_last    = rd_beat && (rcnt_q == clen_q - CW'(1));
  assign wr_ctrl_hs = (state_q == ST_WR_REQ) && dma.dma_write_ctrl_ready;
  assign wr_beat    = (state_q == ST_WR_DATA) && (wcnt_q < clen_q) && dma.dma_write_chnl_ready;
  assign wr_last    = wr_beat && (wcnt_q == clen_q - CW'(1));

  hu_audiodec_chunk_buf #(
    .DMA_WIDTH (DMA_WIDTH),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .wr_en_i   (rd_beat),
    .wr_addr_i (rcnt_q[AW-1:0]),
    .wr_data_i (dma.dma_read_chnl_data),
    .rd_addr_i (wcnt_q[AW-1:0]),
    .rd_data_o (buf_rd_dat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_off_q <= '0;
      mode_q   <= '0;
      shift_q  <= '0;
      rem_q    <= '0;
      base_q   <= '0;
      clen_q   <= '0;
      rcnt_q   <= '0;
      wcnt_q   <= '0;
      err_q    <= 1'b0;
      chunks_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_off_q <= wr_off_d;
      mode_q   <= mode_d;
      shift_q  <= shift_d;
      rem_q    <= rem_d;
      base_q   <= base_d;
      clen_q   <= clen_d;
      rcnt_q   <= rcnt_d;
      wcnt_q   <= wcnt_d;
      err_q    <= err_d;
      chunks_q <= chunks_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (conf_done) state_d = (conf_info_len == 32'd0) ? ST_DONE : ST_RD_REQ;
      ST_RD_REQ:  if (rd_ctrl_hs) state_d = ST_RD_DATA;
      ST_RD_DATA: if (rd_last) state_d = ST_WR_REQ;
      ST_WR_REQ:  if (wr_ctrl_hs) state_d = ST_WR_DATA;
      ST_WR_DATA: if (wr_last) state_d = (rem_q == 32'(clen_q)) ? ST_DONE : ST_RD_REQ;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Next chunk length is computed alongside the remaining-count update so it is
  // already registered when RD_REQ presents it.
  always_comb begin
    wr_off_d = wr_off_q;
    mode_d   = mode_q;
    shift_d  = shift_q;
    rem_d    = rem_q;
    base_d   = base_q;
    clen_d   = clen_q;
    rcnt_d   = rcnt_q;
    wcnt_d   = wcnt_q;
    err_d    = err_q;
    chunks_d = chunks_q;
    if (state_q == ST_IDLE && conf_done) begin
      wr_off_d = conf_info_wr_offset;
      mode_d   = conf_info_mode[1:0];
      shift_d  = conf_info_shift[4:0];
      rem_d    = conf_info_len;
      base_d   = '0;
      clen_d   = chunk_len(conf_info_len);
      rcnt_d   = '0;
      wcnt_d   = '0;
      err_d    = (conf_info_mode[1:0] == 2'd3);
      chunks_d = '0;
    end
    if (rd_beat) rcnt_d = rd_last ? '0 : rcnt_q + CW'(1);
    if (wr_beat) wcnt_d = wr_last ? '0 : wcnt_q + CW'(1);
    if (wr_last) begin
      base_d   = base_q + 32'(clen_q);
      rem_d    = rem_q - 32'(clen_q);
      clen_d   = chunk_len(rem_q - 32'(clen_q));
      chunks_d = chunks_q + 16'd1;
    end
  end

  always_comb begin
    wr_dat = '0;
    for (int l = 0; l < LANES; l++) begin
      wr_dat[l*32 +: 32] = lane_op(mode_q, shift_q, buf_rd_dat[l*32 +: 32]);
    end
  end

  always_comb begin
    dma.dma_read_ctrl_valid        = (state_q == ST_RD_REQ);
    dma.dma_read_ctrl_data_index   = base_q;
    dma.dma_read_ctrl_data_length  = 32'(clen_q);
    dma.dma_read_ctrl_data_size    = SIZE_CODE;
    dma.dma_read_chnl_ready        = (state_q == ST_RD_DATA) && (rcnt_q < clen_q);
    dma.dma_write_ctrl_valid       = (state_q == ST_WR_REQ);
    dma.dma_write_ctrl_data_index  = wr_off_q + base_q;
    dma.dma_write_ctrl_data_length = 32'(clen_q);
    dma.dma_write_ctrl_data_size   = SIZE_CODE;
    dma.dma_write_chnl_valid       = (state_q == ST_WR_DATA) && (wcnt_q < clen_q);
    dma.dma_write_chnl_data        = wr_dat;
    acc_done                       = (state_q == ST_DONE);
    debug                          = '0;
    debug[DBG_STATE_LSB +: 3]      = state_q;
    debug[DBG_ERR_BIT]             = err_q;
    debug[DBG_CHUNK_LSB +: 16]     = chunks_q;
  end
endmodule

// File: tb/tb_hu_audiodec_rtl_dma_chunked.sv
// Directed bench: 32-bit instance driven by a memory-slave model, 64-bit instance by a fixed sequence.
module tb_hu_audiodec_rtl_dma_chunked;
  logic        clk;
  logic        rst;
  logic [31:0] conf_info_len, conf_info_wr_offset, conf_info_mode, conf_info_shift;
  logic        conf_done32, conf_done64;
  logic        acc32, acc64;
  logic [31:0] dbg32, dbg64;

  hu_audiodec_rtl_dma_chunked_if #(.DMA_WIDTH(32)) d32 ();
  hu_audiodec_rtl_dma_chunked_if #(.DMA_WIDTH(64)) d64 ();

  hu_audiodec_rtl_dma_chunked #(.DMA_WIDTH(32), .BUF_DEPTH(64)) u_dut32 (
    .clk(clk), .rst(rst), .conf_info_len(conf_info_len), .conf_info_wr_offset(conf_info_wr_offset),
    .conf_info_mode(conf_info_mode), .conf_info_shift(conf_info_shift), .conf_done(conf_done32),
    .acc_done(acc32), .debug(dbg32), .dma(d32)
  );

  hu_audiodec_rtl_dma_chunked #(.DMA_WIDTH(64), .BUF_DEPTH(4)) u_dut64 (
    .clk(clk), .rst(rst), .conf_info_len(conf_info_len), .conf_info_wr_offset(conf_info_wr_offset),
    .conf_info_mode(conf_info_mode), .conf_info_shift(conf_info_shift), .conf_done(conf_done64),
    .acc_done(acc64), .debug(dbg64), .dma(d64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_op(input logic [1:0] m, input logic [4:0] s, input logic [31:0] x);
    case (m)
      2'd1:    return ~x + 32'd1;
      2'd2:    return (x >> s) | (x[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      default: return x;
    endcase
  endfunction

  // Memory-slave model state for the 32-bit instance
  logic [31:0] src    [0:255];
  logic [31:0] wr_mem [0:1023];
  logic [63:0] rd_reqs[$];
  logic [63:0] wr_reqs[$];
  bit          rand_en = 0;
  int          rd_ptr = 0, rd_left = 0, wr_ptr = 0, wr_cnt = 0;
  int          acc_cnt = 0, acc_cyc = 0, last_wr_cyc = 0, conf_cyc = 0;
  bit          ctrl_seen = 0, stall_used = 0;
  int          stall_cnt = 0, stall_vld = 0;
  bit          wst_pend = 0, wcs_pend = 0;
  logic [31:0] wst_dat, wcs_idx;

  function automatic logic rbit();
    return rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  initial begin
    d32.dma_read_ctrl_ready  = 1'b0;
    d32.dma_write_ctrl_ready = 1'b0;
    d32.dma_write_chnl_ready = 1'b0;
    d32.dma_read_chnl_valid  = 1'b0;
    d32.dma_read_chnl_data   = '0;
    forever begin
      @(negedge clk);
      d32.dma_read_ctrl_ready  = rbit();
      d32.dma_write_ctrl_ready = rbit();
      d32.dma_write_chnl_ready = (stall_cnt > 0) ? 1'b0 : rbit();
      d32.dma_read_chnl_valid  = (rd_left > 0) && rbit();
      d32.dma_read_chnl_data   = src[rd_ptr & 255];
      #1;
      if (d32.dma_read_ctrl_valid || d32.dma_write_ctrl_valid) ctrl_seen = 1;
      if (acc32) begin acc_cnt++; acc_cyc = cyc; end
      if (wst_pend) begin
        chk("wr_stall_vld", 64'(d32.dma_write_chnl_valid), 64'd1);
        chk("wr_stall_dat", 64'(d32.dma_write_chnl_data), 64'(wst_dat));
      end
      wst_pend = d32.dma_write_chnl_valid && !d32.dma_write_chnl_ready;
      wst_dat  = d32.dma_write_chnl_data;
      if (wcs_pend) chk("wr_ctrl_stall_idx", 64'(d32.dma_write_ctrl_data_index), 64'(wcs_idx));
      wcs_pend = d32.dma_write_ctrl_valid && !d32.dma_write_ctrl_ready;
      wcs_idx  = d32.dma_write_ctrl_data_index;
      if (stall_cnt > 0) begin
        stall_cnt--;
        if (d32.dma_write_chnl_valid) stall_vld++;
      end
      if (d32.dma_read_ctrl_valid && d32.dma_read_ctrl_ready) begin
        rd_reqs.push_back({d32.dma_read_ctrl_data_index, d32.dma_read_ctrl_data_length});
        rd_ptr  = int'(d32.dma_read_ctrl_data_index);
        rd_left = int'(d32.dma_read_ctrl_data_length);
      end
      if (d32.dma_read_chnl_valid && d32.dma_read_chnl_ready) begin
        rd_ptr++;
        rd_left--;
      end
      if (d32.dma_write_ctrl_valid && d32.dma_write_ctrl_ready) begin
        wr_reqs.push_back({d32.dma_write_ctrl_data_index, d32.dma_write_ctrl_data_length});
        wr_ptr = int'(d32.dma_write_ctrl_data_index);
      end
      if (d32.dma_write_chnl_valid && d32.dma_write_chnl_ready) begin
        wr_mem[wr_ptr & 1023] = d32.dma_write_chnl_data;
        wr_ptr++;
        wr_cnt++;
        last_wr_cyc = cyc;
        if (rand_en && wr_cnt == 20 && !stall_used) begin
          stall_cnt  = 5;
          stall_used = 1;
        end
      end
    end
  end

  task automatic start32(input logic [31:0] len, input logic [31:0] off, input logic [31:0] mode,
                         input logic [31:0] sh, input bit rnd);
    rd_reqs.delete();
    wr_reqs.delete();
    wr_cnt = 0; acc_cnt = 0; ctrl_seen = 0; rand_en = rnd; rd_left = 0;
    stall_used = 0; stall_vld = 0; stall_cnt = 0; wst_pend = 0; wcs_pend = 0;
    for (int i = 0; i < 1024; i++) wr_mem[i] = 32'hDEAD_BEEF;
    @(negedge clk);
    conf_info_len = len; conf_info_wr_offset = off; conf_info_mode = mode; conf_info_shift = sh;
    conf_done32 = 1'b1;
    conf_cyc = cyc;
    @(negedge clk);
    conf_done32 = 1'b0;
  endtask

  task automatic wait32(input int budget);
    for (int i = 0; i < budget && acc_cnt == 0; i++) @(negedge clk);
    chk("acc_timeout", 64'(acc_cnt != 0), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  int          errs;
  logic [31:0] exp_w;

  initial begin
    rst = 1'b1;
    conf_done32 = 1'b0; conf_done64 = 1'b0;
    conf_info_len = '0; conf_info_wr_offset = '0; conf_info_mode = '0; conf_info_shift = '0;
    d64.dma_read_ctrl_ready  = 1'b1;
    d64.dma_write_ctrl_ready = 1'b1;
    d64.dma_write_chnl_ready = 1'b1;
    d64.dma_read_chnl_valid  = 1'b1;
    d64.dma_read_chnl_data   = {32'd1, 32'd2};
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_valids32", 64'({d32.dma_read_ctrl_valid, d32.dma_read_chnl_ready, d32.dma_write_ctrl_valid,
                             d32.dma_write_chnl_valid, acc32}), 64'd0);
    chk("rst_debug32", 64'(dbg32), 64'd0);
    chk("rst_valids64", 64'({d64.dma_read_ctrl_valid, d64.dma_read_chnl_ready, d64.dma_write_ctrl_valid,
                             d64.dma_write_chnl_valid, acc64}), 64'd0);
    chk("size32", 64'({d32.dma_read_ctrl_data_size, d32.dma_write_ctrl_data_size}), 64'h12);
    rst = 1'b0;

    // Copy, single chunk
    for (int i = 0; i < 4; i++) src[i] = 32'(i + 1);
    start32(4, 32'h100, 0, 0, 0);
    wait32(200);
    chk("copy_nrd", 64'(rd_reqs.size()), 64'd1);
    chk("copy_rd0", rd_reqs[0], {32'd0, 32'd4});
    chk("copy_nwr", 64'(wr_reqs.size()), 64'd1);
    chk("copy_wr0", wr_reqs[0], {32'h100, 32'd4});
    for (int i = 0; i < 4; i++) chk("copy_dat", 64'(wr_mem[32'h100 + i]), 64'(i + 1));
    chk("copy_acc_lat", 64'(acc_cyc - last_wr_cyc), 64'd1);
    chk("copy_acc_once", 64'(acc_cnt), 64'd1);

    // Chunking: 150 beats -> 64, 64, 22
    for (int i = 0; i < 150; i++) src[i] = 32'(i * 3 + 7);
    start32(150, 32'h200, 0, 0, 0);
    wait32(2000);
    chk("chunk_nrd", 64'(rd_reqs.size()), 64'd3);
    chk("chunk_rd0", rd_reqs[0], {32'd0, 32'd64});
    chk("chunk_rd1", rd_reqs[1], {32'd64, 32'd64});
    chk("chunk_rd2", rd_reqs[2], {32'd128, 32'd22});
    chk("chunk_nwr", 64'(wr_reqs.size()), 64'd3);
    chk("chunk_wr0", wr_reqs[0], {32'h200, 32'd64});
    chk("chunk_wr1", wr_reqs[1], {32'h240, 32'd64});
    chk("chunk_wr2", wr_reqs[2], {32'h280, 32'd22});
    errs = 0;
    for (int i = 0; i < 150; i++) if (wr_mem[32'h200 + i] !== 32'(i * 3 + 7)) errs++;
    chk("chunk_data_bad_beats", 64'(errs), 64'd0);
    chk("chunk_count", 64'(dbg32[31:16]), 64'd3);
    chk("chunk_idle", 64'(dbg32[2:0]), 64'd0);

    // Negate
    src[0] = 32'h0000_0005; src[1] = 32'h8000_0000;
    start32(2, 32'h10, 1, 0, 0);
    wait32(200);
    chk("neg_5", 64'(wr_mem[32'h10]), 64'hFFFF_FFFB);
    chk("neg_min", 64'(wr_mem[32'h11]), 64'h8000_0000);

    // Arithmetic shift right by 4
    src[0] = 32'hF000_0000; src[1] = 32'h7000_0000;
    start32(2, 32'h20, 2, 4, 0);
    wait32(200);
    chk("asr_neg", 64'(wr_mem[32'h20]), 64'hFF00_0000);
    chk("asr_pos", 64'(wr_mem[32'h21]), 64'h0700_0000);

    // Reserved mode copies and flags, flag clears on next start
    src[0] = 32'h1234_5678;
    start32(1, 32'h50, 3, 0, 0);
    wait32(200);
    chk("mode3_copy", 64'(wr_mem[32'h50]), 64'h1234_5678);
    chk("mode3_err", 64'(dbg32[3]), 64'd1);
    start32(1, 32'h50, 0, 0, 0);
    wait32(200);
    chk("mode_err_clear", 64'(dbg32[3]), 64'd0);

    // Zero length
    start32(0, 32'h0, 0, 0, 0);
    wait32(50);
    chk("zl_no_ctrl", 64'(ctrl_seen), 64'd0);
    chk("zl_acc_lat", 64'(acc_cyc - conf_cyc), 64'd1);
    chk("zl_acc_once", 64'(acc_cnt), 64'd1);

    // Random back-pressure with a 5-cycle write stall mid-chunk
    for (int i = 0; i < 100; i++) src[i] = $urandom();
    start32(100, 32'h300, 2, 7, 1);
    wait32(5000);
    chk("bp_beats", 64'(wr_cnt), 64'd100);
    chk("bp_stall_cycles", 64'(stall_vld), 64'd5);
    chk("bp_rd1", (rd_reqs.size() == 2) ? rd_reqs[1] : 64'd0, {32'd64, 32'd36});
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      exp_w = model_op(2'd2, 5'd7, src[i]);
      if (wr_mem[32'h300 + i] !== exp_w) errs++;
    end
    chk("bp_scoreboard_bad_beats", 64'(errs), 64'd0);

    // Reset during RD_DATA
    start32(40, 32'h0, 0, 0, 0);
    for (int i = 0; i < 200 && !(d32.dma_read_chnl_ready && rd_left > 0 && rd_left < 30); i++) @(negedge clk);
    chk("rst_reach_rd", 64'(d32.dma_read_chnl_ready), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valids", 64'({d32.dma_read_ctrl_valid, d32.dma_read_chnl_ready, d32.dma_write_ctrl_valid,
                              d32.dma_write_chnl_valid, acc32}), 64'd0);
    chk("midrst_debug", 64'(dbg32), 64'd0);
    repeat (5) @(negedge clk);
    chk("midrst_no_rd_hs", 64'(rd_reqs.size()), 64'd1);
    chk("midrst_no_wr_hs", 64'(wr_reqs.size()), 64'd0);
    src[0] = 32'hA; src[1] = 32'hB;
    start32(2, 32'h80, 0, 0, 0);
    wait32(200);
    chk("post_rst_d0", 64'(wr_mem[32'h80]), 64'hA);
    chk("post_rst_d1", 64'(wr_mem[32'h81]), 64'hB);
    chk("post_rst_acc", 64'(acc_cnt), 64'd1);

    // 64-bit instance, negate on both lanes
    @(negedge clk);
    conf_info_len = 1; conf_info_wr_offset = 0; conf_info_mode = 1; conf_info_shift = 0;
    conf_done64 = 1'b1;
    @(negedge clk);
    conf_done64 = 1'b0;
    for (int i = 0; i < 100 && !d64.dma_write_chnl_valid; i++) @(negedge clk);
    chk("w64_vld", 64'(d64.dma_write_chnl_valid), 64'd1);
    chk("w64_dat", d64.dma_write_chnl_data, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("w64_size", 64'({d64.dma_read_ctrl_data_size, d64.dma_write_ctrl_data_size}), 64'h1B);
    for (int i = 0; i < 20 && !acc64; i++) @(negedge clk);
    chk("w64_acc", 64'(acc64), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
